// File: rtl/mpu_transpose_sequencer_if.sv
// rtl/mpu_transpose_sequencer_if.sv - byte-serial input/output stream bundle for the transpose sequencer
interface mpu_transpose_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  // Producer of input elements and consumer of output elements
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  // The sequencer side
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/mpu_transpose_sequencer.sv
// rtl/mpu_transpose_sequencer.sv - loads a 5x5 byte matrix, transposes it, drains it byte-serially
module mpu_transpose_sequencer (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear,
  output logic                            busy,
  mpu_transpose_sequencer_if.slave        bus
);

  localparam int ELEMENT_WIDTH = 8;
  localparam int DIM           = 5;
  localparam int N_ELEM        = DIM * DIM;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_STORE   = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_next_state;
  logic [2:0]                       r_row;
  logic [2:0]                       r_col;
  logic [ELEMENT_WIDTH-1:0]         r_load   [N_ELEM];
  logic [ELEMENT_WIDTH-1:0]         r_result [N_ELEM];
  logic [N_ELEM*ELEMENT_WIDTH-1:0]  w_load_flat;
  logic [N_ELEM*ELEMENT_WIDTH-1:0]  w_trans_flat;
  logic [4:0]                       w_idx;
  logic                             w_in_ready;
  logic                             w_out_valid;
  logic                             w_in_fire;
  logic                             w_out_fire;
  logic                             w_at_end;

  // row/col address the same flat buffer index in both LOAD and STORE
  assign w_idx       = ({2'b00, r_row} * 5'd5) + {2'b00, r_col};
  assign w_at_end    = (r_row == 3'd4) && (r_col == 3'd4);
  assign w_in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_out_valid = (r_state == S_STORE);

  // clear wins over a same-cycle handshake: the element is treated as not moved
  assign w_in_fire   = bus.in_valid  & w_in_ready  & ~clear;
  assign w_out_fire  = w_out_valid   & bus.out_ready & ~clear;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_result[w_idx];
  assign bus.out_last  = w_out_valid & w_at_end;
  assign busy          = (r_state != S_IDLE);

  for (genvar g = 0; g < N_ELEM; g++) begin : g_flat
    assign w_load_flat[g*ELEMENT_WIDTH +: ELEMENT_WIDTH] = r_load[g];
  end

  Transpose u_transpose (
    .i_matrix (w_load_flat),
    .o_matrix (w_trans_flat)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; COMPUTE always lasts exactly one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_in_fire && w_at_end) begin
          w_next_state = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        w_next_state = S_STORE;
      end
      S_STORE: begin
        if (w_out_fire && w_at_end) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (clear) begin
      w_next_state = S_IDLE;
    end
  end

  // Row/column walk shared by load and drain; zero whenever IDLE or COMPUTE is entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row <= 3'd0;
      r_col <= 3'd0;
    end else if (clear) begin
      r_row <= 3'd0;
      r_col <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_row <= 3'd0;
            r_col <= 3'd1;
          end
        end
        S_LOAD, S_STORE: begin
          if ((r_state == S_LOAD) ? w_in_fire : w_out_fire) begin
            if (w_at_end) begin
              r_row <= 3'd0;
              r_col <= 3'd0;
            end else if (r_col == 3'd4) begin
              r_row <= r_row + 3'd1;
              r_col <= 3'd0;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        default: begin
          r_row <= 3'd0;
          r_col <= 3'd0;
        end
      endcase
    end
  end

  // Load buffer captures each accepted input element at the current row/col
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ELEM; i++) begin
        r_load[i] <= '0;
      end
    end else if (w_in_fire) begin
      r_load[w_idx] <= bus.in_data;
    end
  end

  // Result buffer snapshots the transpose during the single COMPUTE cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ELEM; i++) begin
        r_result[i] <= '0;
      end
    end else if ((r_state == S_COMPUTE) && !clear) begin
      for (int i = 0; i < N_ELEM; i++) begin
        r_result[i] <= w_trans_flat[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
    end
  end

endmodule

// Purely combinational 5x5 transpose: out[i][j] = in[j][i], row-major flattened
module Transpose (
  input  logic [199:0] i_matrix,
  output logic [199:0] o_matrix
);

  localparam int ELEMENT_WIDTH = 8;
  localparam int DIM           = 5;

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      assign o_matrix[(i*DIM+j)*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
             i_matrix[(j*DIM+i)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end
  end

endmodule

// File: tb/tb_mpu_transpose_sequencer.sv
// tb/tb_mpu_transpose_sequencer.sv - scoreboard bench for the transpose sequencer
module tb_mpu_transpose_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic clear;
  logic busy;

  mpu_transpose_sequencer_if bus ();

  mpu_transpose_sequencer dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'd0;
  logic       stall_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks hold-while-stalled
  always @(negedge clock) begin
    logic [8:0] e;
    if (!reset) begin
      if (stall_q && bus.out_valid) begin
        check("stall_data", bus.out_data, stall_data);
        check("stall_last", bus.out_last, stall_last);
      end
      if (bus.out_valid) begin
        check("in_ready_in_store", bus.in_ready, 0);
      end
      if (bus.out_valid && bus.out_ready && !clear) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got data %0h with empty scoreboard", bus.out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e[7:0]);
          check("out_last", bus.out_last, e[8]);
        end
      end
      stall_q    = bus.out_valid && !bus.out_ready && !clear;
      stall_data = bus.out_data;
      stall_last = bus.out_last;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_expected(input int base);
    logic [8:0] e;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        e[7:0] = 8'(base + c * 5 + r);
        e[8]   = (r == 4) && (c == 4);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_elems(input int base, input int count, input int gap_at);
    int guard;
    for (int k = 0; k < count; k++) begin
      if (k == gap_at) begin
        bus.in_valid = 1'b0;
        repeat (3) begin
          tick();
          check("busy_in_gap", busy, 1);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(base + k);
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) begin
        check("in_ready_wait", bus.in_ready, 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_matrix(input int base, input int gap_at);
    send_elems(base, 25, gap_at);
    push_expected(base);
    check("compute_out_valid", bus.out_valid, 0);
    check("compute_in_ready", bus.in_ready, 0);
    check("compute_busy", busy, 1);
    tick();
    check("store_out_valid", bus.out_valid, 1);
  endtask

  task automatic drain(input bit random_ready);
    int guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d outputs missing", sb.size());
      sb.delete();
    end
    check("idle_busy", busy, 0);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    int guard;
    reset         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", bus.out_data, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Plain ramp 0..24
    send_matrix(0, -1);
    drain(1'b0);

    // Random backpressure
    send_matrix(30, -1);
    drain(1'b1);

    // Three-cycle input gap at element 12
    send_matrix(0, 12);
    drain(1'b0);

    // clear together with element 10, then a fresh load
    send_elems(200, 10, -1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    clear        = 1'b1;
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_load_busy", busy, 0);
    check("clr_load_in_ready", bus.in_ready, 1);
    check("clr_load_row", dut.r_row, 0);
    check("clr_load_col", dut.r_col, 0);
    send_matrix(50, -1);
    drain(1'b0);

    // clear after 7 outputs of the drain
    send_matrix(0, -1);
    bus.out_ready = 1'b1;
    guard = 0;
    while (sb.size() > 18 && guard < 100) begin
      tick();
      guard++;
    end
    check("clr_store_seen7", sb.size(), 18);
    clear = 1'b1;
    tick();
    clear         = 1'b0;
    bus.out_ready = 1'b0;
    check("clr_store_out_valid", bus.out_valid, 0);
    check("clr_store_busy", busy, 0);
    check("clr_store_row", dut.r_row, 0);
    check("clr_store_col", dut.r_col, 0);
    sb.delete();

    // Asynchronous reset mid-load
    send_elems(7, 12, -1);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_last", bus.out_last, 0);
    check("arst_out_data", bus.out_data, 0);
    #2;
    reset = 1'b0;
    tick();

    // Back-to-back matrices
    send_matrix(0, -1);
    drain(1'b0);
    send_matrix(100, -1);
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
